// File: rtl/ifu_bpu.sv
// Gshare branch direction predictor for the fetch stage.
// A table of 2-bit saturating counters is indexed by pc[IDX_W+1:2] XOR a
// speculative global history. Resolved branches from execute train the table,
// advance the architectural history and, on a mispredict, repair the
// speculative history from it.
module ifu_bpu #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [XLEN-1:0]  i_req_pc,
  input  logic             i_req_isbxx,
  input  logic [XLEN-1:0]  i_req_imm,
  output logic             o_pred_valid,
  output logic             o_pred_taken,
  output logic [XLEN-1:0]  o_pred_jaddr,
  output logic [IDX_W-1:0] o_pred_idx,
  input  logic             i_upd_valid,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_taken,
  input  logic             i_upd_mispred
);

  localparam int ENTRIES = 1 << IDX_W;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] sweep;
  logic [IDX_W-1:0] sweep_next;

  logic [1:0]       ctr_table [ENTRIES];
  logic [IDX_W-1:0] spec_ghr;
  logic [IDX_W-1:0] arch_ghr;

  logic             run;
  logic             accept;
  logic             upd_en;
  logic             mispred_en;
  logic [IDX_W-1:0] lookup_idx;
  logic [1:0]       upd_ctr_old;
  logic [1:0]       upd_ctr_new;
  logic [1:0]       lookup_ctr;
  logic             lookup_taken;
  logic [XLEN-1:0]  jaddr_next;

  assign run         = (state == RUN);
  assign o_req_ready = run;
  assign accept      = i_req_valid & run;
  assign upd_en      = i_upd_valid & run;
  assign mispred_en  = upd_en & i_upd_mispred;
  assign lookup_idx  = i_req_pc[IDX_W+1:2] ^ spec_ghr;

  // State and sweep pointer register; reset always restarts the table sweep
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= INIT;
      sweep <= '0;
    end else begin
      state <= state_next;
      sweep <= sweep_next;
    end
  end

  // Sweep one entry per cycle in INIT and leave for RUN after the last entry
  always_comb begin
    state_next = state;
    sweep_next = sweep;
    case (state)
      INIT: begin
        sweep_next = sweep + 1'b1;
        if (&sweep) begin
          state_next = RUN;
        end
      end
      RUN: begin
        state_next = RUN;
      end
      default: begin
        state_next = INIT;
      end
    endcase
  end

  // Saturating counter step for the resolved branch
  always_comb begin
    upd_ctr_old = ctr_table[i_upd_idx];
    upd_ctr_new = upd_ctr_old;
    if (i_upd_taken) begin
      if (upd_ctr_old != 2'd3) begin
        upd_ctr_new = upd_ctr_old + 2'd1;
      end
    end else begin
      if (upd_ctr_old != 2'd0) begin
        upd_ctr_new = upd_ctr_old - 2'd1;
      end
    end
  end

  // Lookup with write-first bypass so a same-cycle update is seen by fetch
  always_comb begin
    lookup_ctr = ctr_table[lookup_idx];
    if (upd_en && (i_upd_idx == lookup_idx)) begin
      lookup_ctr = upd_ctr_new;
    end
    lookup_taken = i_req_isbxx & lookup_ctr[1];
    jaddr_next   = lookup_taken ? (i_req_pc + i_req_imm) : (i_req_pc + XLEN'(4));
  end

  // Counter table: weakly not-taken fill during INIT, training during RUN
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (state == INIT) begin
        ctr_table[sweep] <= 2'b01;
      end else if (upd_en) begin
        ctr_table[i_upd_idx] <= upd_ctr_new;
      end
    end
  end

  // Global histories; a mispredict repair overrides the speculative shift
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      spec_ghr <= '0;
      arch_ghr <= '0;
    end else begin
      if (upd_en) begin
        arch_ghr <= {arch_ghr[IDX_W-2:0], i_upd_taken};
      end
      if (mispred_en) begin
        spec_ghr <= {arch_ghr[IDX_W-2:0], i_upd_taken};
      end else if (accept && i_req_isbxx) begin
        spec_ghr <= {spec_ghr[IDX_W-2:0], lookup_taken};
      end
    end
  end

  // Registered prediction, valid for one cycle per accepted request
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pred_valid <= 1'b0;
      o_pred_taken <= 1'b0;
      o_pred_jaddr <= '0;
      o_pred_idx   <= '0;
    end else begin
      o_pred_valid <= accept;
      if (accept) begin
        o_pred_taken <= lookup_taken;
        o_pred_jaddr <= jaddr_next;
        o_pred_idx   <= i_req_isbxx ? lookup_idx : '0;
      end
    end
  end

endmodule

// File: tb/tb_ifu_bpu.sv
// Directed self-checking bench for the gshare predictor.
module tb_ifu_bpu;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [31:0] i_req_pc = '0;
  logic        i_req_isbxx = 1'b0;
  logic [31:0] i_req_imm = '0;
  logic        o_pred_valid;
  logic        o_pred_taken;
  logic [31:0] o_pred_jaddr;
  logic [5:0]  o_pred_idx;
  logic        i_upd_valid = 1'b0;
  logic [5:0]  i_upd_idx = '0;
  logic        i_upd_taken = 1'b0;
  logic        i_upd_mispred = 1'b0;

  int checks = 0;
  int failures = 0;

  ifu_bpu #(.XLEN(32), .IDX_W(6)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_pc      (i_req_pc),
    .i_req_isbxx   (i_req_isbxx),
    .i_req_imm     (i_req_imm),
    .o_pred_valid  (o_pred_valid),
    .o_pred_taken  (o_pred_taken),
    .o_pred_jaddr  (o_pred_jaddr),
    .o_pred_idx    (o_pred_idx),
    .i_upd_valid   (i_upd_valid),
    .i_upd_idx     (i_upd_idx),
    .i_upd_taken   (i_upd_taken),
    .i_upd_mispred (i_upd_mispred)
  );

  // Free-running 10 ns clock
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic isb, input logic [31:0] pc,
                               input logic [31:0] imm, input logic uv, input logic [5:0] uidx,
                               input logic ut, input logic um);
    i_req_valid   = rv;
    i_req_isbxx   = isb;
    i_req_pc      = pc;
    i_req_imm     = imm;
    i_upd_valid   = uv;
    i_upd_idx     = uidx;
    i_upd_taken   = ut;
    i_upd_mispred = um;
    step();
    i_req_valid   = 1'b0;
    i_req_isbxx   = 1'b0;
    i_upd_valid   = 1'b0;
    i_upd_mispred = 1'b0;
  endtask

  task automatic sendUpdate(input logic [5:0] idx, input logic taken);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, idx, taken, 1'b0);
  endtask

  task automatic sendBranch(input logic [31:0] pc, input logic [31:0] imm);
    applyStimulus(1'b1, 1'b1, pc, imm, 1'b0, 6'd0, 1'b0, 1'b0);
  endtask

  task automatic resetDut(output int lowCount);
    i_rst = 1'b1;
    repeat (3) step();
    i_rst = 1'b0;
    lowCount = 0;
    while (!o_req_ready && lowCount < 200) begin
      lowCount++;
      step();
    end
  endtask

  initial begin
    int n;

    // Reset and init, with a branch request and a bogus update held throughout
    i_req_valid   = 1'b1;
    i_req_isbxx   = 1'b1;
    i_req_pc      = 32'h14;
    i_req_imm     = 32'h100;
    i_upd_valid   = 1'b1;
    i_upd_idx     = 6'd5;
    i_upd_taken   = 1'b1;
    i_upd_mispred = 1'b1;
    i_rst = 1'b1;
    repeat (3) step();
    checkOutput("rst_ready", 32'(o_req_ready), 32'd0);
    checkOutput("rst_valid", 32'(o_pred_valid), 32'd0);
    checkOutput("rst_taken", 32'(o_pred_taken), 32'd0);
    checkOutput("rst_jaddr", o_pred_jaddr, 32'h0);
    checkOutput("rst_idx", 32'(o_pred_idx), 32'd0);
    i_rst = 1'b0;
    n = 0;
    while (!o_req_ready && n < 200) begin
      n++;
      step();
    end
    checkOutput("init_len", 32'(n), 32'd64);
    checkOutput("init_no_pred", 32'(o_pred_valid), 32'd0);
    i_upd_valid   = 1'b0;
    i_upd_mispred = 1'b0;
    step();
    i_req_valid = 1'b0;
    i_req_isbxx = 1'b0;
    checkOutput("first_valid", 32'(o_pred_valid), 32'd1);
    checkOutput("first_taken", 32'(o_pred_taken), 32'd0);
    checkOutput("first_jaddr", o_pred_jaddr, 32'h18);
    checkOutput("first_idx", 32'(o_pred_idx), 32'd5);
    step();
    checkOutput("ready_stays", 32'(o_req_ready), 32'd1);

    // Training up and down at idx 5
    resetDut(n);
    sendUpdate(6'd5, 1'b1);
    sendUpdate(6'd5, 1'b1);
    sendBranch(32'h14, 32'h100);
    checkOutput("train_taken", 32'(o_pred_taken), 32'd1);
    checkOutput("train_jaddr", o_pred_jaddr, 32'h114);
    checkOutput("train_idx", 32'(o_pred_idx), 32'd5);
    repeat (4) sendUpdate(6'd5, 1'b0);
    sendBranch(32'h10, 32'h100);
    checkOutput("untrain_idx", 32'(o_pred_idx), 32'd5);
    checkOutput("untrain_taken", 32'(o_pred_taken), 32'd0);
    checkOutput("untrain_jaddr", o_pred_jaddr, 32'h14);
    sendUpdate(6'd5, 1'b1);
    sendBranch(32'h1C, 32'h100);
    checkOutput("floor_idx", 32'(o_pred_idx), 32'd5);
    checkOutput("floor_taken", 32'(o_pred_taken), 32'd0);

    // Saturation at the top
    resetDut(n);
    repeat (10) sendUpdate(6'd9, 1'b1);
    sendUpdate(6'd9, 1'b0);
    repeat (4) sendUpdate(6'd11, 1'b1);
    repeat (2) sendUpdate(6'd11, 1'b0);
    sendBranch(32'h24, 32'h40);
    checkOutput("sat_taken", 32'(o_pred_taken), 32'd1);
    checkOutput("sat_jaddr", o_pred_jaddr, 32'h64);
    sendBranch(32'h28, 32'h40);
    checkOutput("sat2_idx", 32'(o_pred_idx), 32'd11);
    checkOutput("sat2_taken", 32'(o_pred_taken), 32'd0);

    // Speculative history build-up and mispredict repair
    resetDut(n);
    sendUpdate(6'd0, 1'b1);
    sendUpdate(6'd1, 1'b1);
    sendUpdate(6'd3, 1'b1);
    repeat (6) sendUpdate(6'd63, 1'b0);
    sendBranch(32'h0, 32'h40);
    checkOutput("spec0_idx", 32'(o_pred_idx), 32'd0);
    checkOutput("spec0_taken", 32'(o_pred_taken), 32'd1);
    sendBranch(32'h0, 32'h40);
    checkOutput("spec1_idx", 32'(o_pred_idx), 32'd1);
    sendBranch(32'h0, 32'h40);
    checkOutput("spec3_idx", 32'(o_pred_idx), 32'd3);
    checkOutput("spec3_jaddr", o_pred_jaddr, 32'h40);
    applyStimulus(1'b1, 1'b1, 32'h0, 32'h40, 1'b1, 6'd63, 1'b0, 1'b1);
    checkOutput("repair_same_idx", 32'(o_pred_idx), 32'd7);
    sendBranch(32'h40, 32'h8);
    checkOutput("repair_idx", 32'(o_pred_idx), 32'h10);
    checkOutput("repair_taken", 32'(o_pred_taken), 32'd0);

    // Same-cycle update and lookup on idx 9, then a non-branch
    resetDut(n);
    applyStimulus(1'b1, 1'b1, 32'h24, 32'h8, 1'b1, 6'd9, 1'b1, 1'b0);
    checkOutput("bypass_taken", 32'(o_pred_taken), 32'd1);
    checkOutput("bypass_jaddr", o_pred_jaddr, 32'h2C);
    applyStimulus(1'b1, 1'b0, 32'h24, 32'h8, 1'b0, 6'd0, 1'b0, 1'b0);
    checkOutput("nonbr_taken", 32'(o_pred_taken), 32'd0);
    checkOutput("nonbr_idx", 32'(o_pred_idx), 32'd0);
    checkOutput("nonbr_jaddr", o_pred_jaddr, 32'h28);
    step();
    checkOutput("valid_one_cycle", 32'(o_pred_valid), 32'd0);

    // Reset in mid-sweep restarts init; then address wrap on a taken branch
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    repeat (30) step();
    checkOutput("mid_init_ready", 32'(o_req_ready), 32'd0);
    resetDut(n);
    checkOutput("reinit_len", 32'(n), 32'd64);
    sendUpdate(6'd60, 1'b1);
    sendBranch(32'hFFFF_FFF0, 32'h20);
    checkOutput("wrap_idx", 32'(o_pred_idx), 32'd60);
    checkOutput("wrap_taken", 32'(o_pred_taken), 32'd1);
    checkOutput("wrap_jaddr", o_pred_jaddr, 32'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
